// File: rtl/mc_alu_pkg.sv
// Shared opcode constants and FSM state type for the registered multi-cycle ALU.
package mc_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASSB = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mc_alu_mul.sv
// Iterative shift-add multiplier: one step per cycle, WIDTH steps, low WIDTH bits of the product.
module mc_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count;
    logic             busy;

    // The final step's addition is folded into the product so the result is ready on the done edge.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = busy && (count == CW'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mc_alu.sv
// Registered ALU with valid/ready input handshake; opcode 11 is an iterative MUL
// only when MC_ALU_MUL_EN is defined, otherwise it decodes as PASS_A.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             a_is_zero,
    output logic             carry
);

    // Handshake: an op is taken at a rising edge where in_valid && in_ready; out_valid is a
    // single-cycle pulse with no backpressure, so the consumer must sample it in that cycle.

    localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(WIDTH);

    logic             accept;
    logic             start_mul;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             shift_oob;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    assign accept    = in_valid && in_ready;
    assign sum       = {1'b0, in_a} + {1'b0, in_b};
    assign diff      = {1'b0, in_a} - {1'b0, in_b};
    assign shift_oob = ({1'b0, in_b} >= SHIFT_LIM);

    always_comb begin
        res       = in_a;
        res_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
            end
            OP_AND:   res = in_a & in_b;
            OP_XOR:   res = in_a ^ in_b;
            OP_PASSB: res = in_b;
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
            end
            OP_SHL:   res = shift_oob ? '0 : (in_a << in_b);
            OP_SHR:   res = shift_oob ? '0 : (in_a >> in_b);
            default:  res = in_a;
        endcase
    end

`ifdef MC_ALU_MUL_EN
    state_t           state;
    state_t           state_next;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign start_mul = accept && (opcode == OP_MUL);
    assign in_ready  = (state == ST_IDLE);

    mc_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end
`else
    assign start_mul = 1'b0;
    assign in_ready  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out   <= '0;
            a_is_zero <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                a_is_zero <= (in_a == '0);
                if (!start_mul) begin
                    alu_out   <= res;
                    carry     <= res_carry;
                    out_valid <= 1'b1;
                end
            end
`ifdef MC_ALU_MUL_EN
            else if (mul_done) begin
                alu_out   <= mul_product;
                carry     <= 1'b0;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu (WIDTH = 8): vector table plus hand-written MUL/reset sequences.
module tb_mc_alu;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic [W-1:0] alu_out;
    logic         a_is_zero;
    logic         carry;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } vec_t;

    vec_t vecs[$];

    mc_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .alu_out   (alu_out),
        .a_is_zero (a_is_zero),
        .carry     (carry)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic c, input logic z);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.c = c; v.z = z;
        vecs.push_back(v);
    endtask

    // driver: present one op at the negedge, check the registered result just after the posedge
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = v.op;
        in_a     = v.a;
        in_b     = v.b;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
        chk($sformatf("vec%0d alu_out", idx), {24'd0, alu_out}, {24'd0, v.res});
        chk($sformatf("vec%0d carry", idx), {31'd0, carry}, {31'd0, v.c});
        chk($sformatf("vec%0d a_is_zero", idx), {31'd0, a_is_zero}, {31'd0, v.z});
    endtask

    task automatic idle_check(input string name, input logic [W-1:0] held);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'hA5;
        in_b     = 8'h5A;
        @(posedge clk);
        #1;
        chk({name, " no pulse"}, {31'd0, out_valid}, 32'd0);
        chk({name, " hold"}, {24'd0, alu_out}, {24'd0, held});
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        opcode   = mc_alu_pkg::OP_ADD;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst alu_out", {24'd0, alu_out}, 32'd0);
        chk("rst carry", {31'd0, carry}, 32'd0);
        chk("rst a_is_zero", {31'd0, a_is_zero}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("post-rst alu_out", {24'd0, alu_out}, 32'd0);
    endtask

`ifdef MC_ALU_MUL_EN
    // accept a MUL and wait (bounded) for its result, checking latency and value
    task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                           input string name);
        int lat;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = mc_alu_pkg::OP_MUL;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        chk({name, " busy after accept"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        opcode = mc_alu_pkg::OP_ADD;
        in_a   = 8'h01;
        in_b   = 8'h01;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) seen = 1'b1;
            else chk({name, " in_ready low while busy"}, {31'd0, in_ready}, 32'd0);
        end
        chk({name, " completed"}, {31'd0, seen}, 32'd1);
        chk({name, " latency"}, lat, 32'd8);
        chk({name, " product"}, {24'd0, alu_out}, {24'd0, exp});
        chk({name, " carry"}, {31'd0, carry}, 32'd0);
        chk({name, " ready at done"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " single pulse"}, {31'd0, out_valid}, 32'd0);
        chk({name, " held"}, {24'd0, alu_out}, {24'd0, exp});
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = 4'd0;
        in_a     = '0;
        in_b     = '0;

        // op, a, b, result, carry, a_is_zero
        add_vec(4'd2,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        add_vec(4'd8,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
        add_vec(4'd2,  8'h00, 8'h03, 8'h03, 1'b0, 1'b1);
        add_vec(4'd2,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
        add_vec(4'd8,  8'h07, 8'h05, 8'h02, 1'b0, 1'b0);
        add_vec(4'd8,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0);
        add_vec(4'd8,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b1);
        add_vec(4'd3,  8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0);
        add_vec(4'd4,  8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0);
        add_vec(4'd5,  8'h3C, 8'h0F, 8'h0F, 1'b0, 1'b0);
        add_vec(4'd7,  8'h3C, 8'h0F, 8'h3C, 1'b0, 1'b0);
        add_vec(4'd0,  8'h3C, 8'h0F, 8'h3C, 1'b0, 1'b0);
        add_vec(4'd1,  8'h3C, 8'h0F, 8'h3C, 1'b0, 1'b0);
        add_vec(4'd6,  8'h3C, 8'h0F, 8'h3C, 1'b0, 1'b0);
        add_vec(4'd12, 8'h3C, 8'h0F, 8'h3C, 1'b0, 1'b0);
        add_vec(4'd15, 8'h3C, 8'h0F, 8'h3C, 1'b0, 1'b0);
        add_vec(4'd9,  8'h81, 8'h01, 8'h02, 1'b0, 1'b0);
        add_vec(4'd10, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0);
        add_vec(4'd9,  8'hFF, 8'h08, 8'h00, 1'b0, 1'b0);
        add_vec(4'd10, 8'hFF, 8'h09, 8'h00, 1'b0, 1'b0);
        add_vec(4'd9,  8'h01, 8'h07, 8'h80, 1'b0, 1'b0);
        add_vec(4'd10, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0);
        add_vec(4'd2,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

        do_reset(2);

        // back-to-back: in_valid stays high across the whole table
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end
        idle_check("after table", vecs[vecs.size()-1].res);

        // reset clears previously written results
        apply(vecs[0], 100);
        do_reset(1);

`ifdef MC_ALU_MUL_EN
        mul_run(8'h0D, 8'h0B, 8'h8F, "mul 0D*0B");
        mul_run(8'hFF, 8'hFF, 8'h01, "mul FF*FF");
        mul_run(8'h00, 8'h37, 8'h00, "mul 00*37");
        chk("mul a_is_zero", {31'd0, a_is_zero}, 32'd1);

        // reset at step 4 of a MUL aborts it
        apply(vecs[8], 200);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = mc_alu_pkg::OP_MUL;
        in_a     = 8'h0D;
        in_b     = 8'h0B;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort alu_out", {24'd0, alu_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) pulses++;
            end
            chk("abort no late pulse", pulses, 32'd0);
        end
        chk("abort ready after", {31'd0, in_ready}, 32'd1);
`else
        // opcode 11 is a single-cycle PASS_A without the multiplier
        begin
            vec_t v;
            v.op = 4'd11; v.a = 8'h2A; v.b = 8'h05; v.res = 8'h2A; v.c = 1'b0; v.z = 1'b0;
            apply(v, 300);
            chk("op11 ready", {31'd0, in_ready}, 32'd1);
            v.a = 8'h00; v.res = 8'h00; v.z = 1'b1;
            apply(v, 301);
        end
        idle_check("after op11", 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_alu.md
# mc_alu

Parametrised, registered successor to the combinational VeriRISC ALU. It accepts one operation per cycle over a valid/ready handshake and registers the result, zero flag and carry flag. Opcodes 0–7 keep their existing ALU meaning; the opcode is widened to 4 bits to add subtract, shifts and an optional iterative multiply. It sits between the controller/register file and the accumulator write-back path.

## Interface
- `WIDTH`, default 8 — data width; legal values are ≥ 2.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `in_valid` input 1 — operands and opcode are valid this cycle.
- `in_ready` output 1 — block can accept; high exactly when the FSM is IDLE.
- `opcode` input 4 — operation select.
- `in_a`, `in_b` input WIDTH — operands.
- `out_valid` output 1 — one-cycle pulse; result registers were updated at the preceding edge.
- `alu_out` output WIDTH — registered result; holds until the next result.
- `a_is_zero` output 1 — registered: `in_a` of the accepted op was 0.
- `carry` output 1 — registered carry/borrow flag.

## Operation
- Accept occurs at a rising edge where `in_valid && in_ready`. With no accept, `alu_out`, `a_is_zero` and `carry` hold their values.
- Opcode map:
  - 2: ADD.
  - 3: AND.
  - 4: XOR.
  - 5: PASS_B.
  - 8: SUB (a−b).
  - 9: SHL (a << b).
  - 10: SHR, logical (a >> b).
  - 11: MUL, low WIDTH bits of a×b.
  - 0, 1, 6, 7, 12–15: PASS_A.
- Arithmetic is modulo 2^WIDTH.
  - ADD: `carry` = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: `carry` = borrow, set when a < b unsigned.
  - All other ops: `carry` = 0.
- Shifts use the full `in_b` as the shift amount. An amount ≥ WIDTH yields 0.
- `a_is_zero` is captured from `in_a` at accept for every opcode, including MUL.
- FSM states:
  - IDLE: single-cycle ops write results at the accept edge and stay in IDLE. An accepted MUL loads the operands, clears the accumulator and counter, and moves to MUL.
  - MUL: one shift-add step per cycle. If the multiplier LSB is set, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right. After WIDTH steps, write `alu_out` = accumulator, `carry` = 0, pulse `out_valid`, and return to IDLE.
- Inputs are ignored while `in_ready` = 0. Operands are captured at accept, so later changes to `in_a`/`in_b` have no effect.

## Timing
- Reset: `alu_out` = 0, `a_is_zero` = 0, `carry` = 0, `out_valid` = 0, `in_ready` = 1, FSM = IDLE, counter = 0.
- Single-cycle ops:
  - Latency 1: accept at edge N gives `out_valid` = 1 during cycle N..N+1.
  - Throughput 1/cycle; back-to-back accepts produce consecutive `out_valid` pulses.
- MUL:
  - Accept at edge N; `in_ready` = 0 from edge N until edge N+WIDTH.
  - Result written at edge N+WIDTH; `out_valid` high for the following cycle; `in_ready` = 1 again in the same cycle.
  - Throughput is one MUL per WIDTH cycles. The next op can be accepted at edge N+WIDTH+1 at the earliest.
- Reset asserted during MUL aborts the operation. No `out_valid` is produced, and all outputs take reset values at that edge.
- `in_valid` asserted in the same cycle as reset is ignored.
- `out_valid` has no backpressure; the consumer must sample it in the pulse cycle.

## Configuration
- Macro: `MC_ALU_MUL_EN`.
- Defined: opcode 11 = iterative MUL as above; the MUL state, counter and accumulator are present.
- Undefined: opcode 11 decodes as PASS_A with single-cycle latency. The FSM reduces to IDLE only, `in_ready` is tied to 1, and no multiplier logic is synthesised.

## Structure
- Shared package `mc_alu_pkg`:
  - 4-bit opcode constants: `OP_ADD`, `OP_AND`, `OP_XOR`, `OP_PASSB`, `OP_SUB`, `OP_SHL`, `OP_SHR`, `OP_MUL`.
  - FSM state enum (`ST_IDLE`, `ST_MUL`).
- Sub-module `mc_alu_mul`: shift-add engine with `start`, `done`, operands and product. It is instantiated only under `MC_ALU_MUL_EN`.
- Single-cycle datapath and flag logic stay in `mc_alu`.

## Test plan
All cases use WIDTH = 8.
1. Reset → check outputs.
   - Stimulus: hold `rst_n` = 0 for 2 cycles, then release.
   - Response: `alu_out` = 0x00, `carry` = 0, `a_is_zero` = 0, `out_valid` = 0, `in_ready` = 1.
2. ADD/SUB flags.
   - ADD 0xF0 + 0x20 → `alu_out` = 0x10, `carry` = 1.
   - SUB 0x05 − 0x07 → 0xFE, `carry` = 1.
   - ADD 0x00 + 0x03 → 0x03, `a_is_zero` = 1.
3. Back-to-back and legacy map.
   - Accept AND, XOR, PASS_B, opcode 7 on consecutive cycles with a = 0x3C, b = 0x0F.
   - Response: four consecutive `out_valid` pulses with 0x0C, 0x33, 0x0F, 0x3C.
4. Shifts.
   - SHL 0x81 by 1 → 0x02.
   - SHR 0x81 by 7 → 0x01.
   - SHL 0xFF by 8 → 0x00.
5. MUL (macro defined).
   - Accept 0x0D × 0x0B at edge N.
   - Response: `in_ready` = 0 for 8 cycles; `out_valid` after edge N+8 with 0x8F; `in_valid` held high during the MUL is ignored.
   - Also 0xFF × 0xFF → 0x01.
6. Reset mid-MUL and macro off.
   - Assert `rst_n` = 0 at step 4 of a MUL → no `out_valid`, `in_ready` = 1 the next cycle.
   - With the macro undefined, opcode 11 with a = 0x2A → 0x2A after 1 cycle.
